// File: rtl/id_hazard_sched_pkg.sv
// Shared definitions for the ID-stage hazard scheduler: forward-select codes
// and the per-stage in-flight writer slot layout.
package id_hazard_sched_pkg;

  localparam logic [1:0] BYP_RF  = 2'b00;
  localparam logic [1:0] BYP_EXE = 2'b01;
  localparam logic [1:0] BYP_MEM = 2'b10;
  localparam logic [1:0] BYP_WB  = 2'b11;

  // Width of slot_t: valid + waddr[4:0] + wen + avail + mem_gene.
  localparam int SLOT_W = 9;

  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic       wen;
    logic       avail;
    logic       mem_gene;
  } slot_t;

  function automatic logic slot_match(input slot_t s, input logic [4:0] addr, input logic en);
    return s.valid & s.wen & (s.waddr == addr) & (addr != 5'd0) & en;
  endfunction

endpackage

// File: rtl/id_hazard_sched_haz_src_match.sv
// Per-source priority match (youngest writer first) returning the hazard
// flag and the forward select for one ID source operand.
module haz_src_match
  import id_hazard_sched_pkg::*;
(
  input  logic [4:0]        src_addr,
  input  logic              src_en,
  input  logic [SLOT_W-1:0] exe_slot,
  input  logic [SLOT_W-1:0] mem_slot,
  input  logic [SLOT_W-1:0] wb_slot,
  output logic              hazard,
  output logic [1:0]        byp_sel
);

  slot_t exe_s;
  slot_t mem_s;
  slot_t wb_s;
  logic  unused_gene_s;

  assign exe_s = slot_t'(exe_slot);
  assign mem_s = slot_t'(mem_slot);
  assign wb_s  = slot_t'(wb_slot);
  // mem_gene only matters while the writer moves EXE to MEM.
  assign unused_gene_s = exe_s.mem_gene ^ mem_s.mem_gene ^ wb_s.mem_gene;

  // First matching slot decides; a not-yet-available result is a hazard.
  always_comb begin
    hazard  = 1'b0;
    byp_sel = BYP_RF;
    if (slot_match(exe_s, src_addr, src_en)) begin
      hazard  = ~exe_s.avail;
      byp_sel = BYP_EXE;
    end else if (slot_match(mem_s, src_addr, src_en)) begin
      hazard  = ~mem_s.avail;
      byp_sel = BYP_MEM;
    end else if (slot_match(wb_s, src_addr, src_en)) begin
      hazard  = ~wb_s.avail;
      byp_sel = BYP_WB;
    end else begin
      hazard  = 1'b0;
      byp_sel = BYP_RF;
    end
  end

endmodule

// File: rtl/id_hazard_sched.sv
// ID issue scheduler: tracks EXE/MEM/WB destination registers, gates ready_go
// and picks bypass sources. Optional stall counter under HAZ_STALL_CNT_EN.
module id_hazard_sched
  import id_hazard_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs_addr,
  input  logic       id_rs_en,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rt_en,
  input  logic [4:0] id_w_addr,
  input  logic       id_w_en,
  input  logic       id_exe_gene,
  input  logic       id_mem_gene,
  input  logic       id_fire,
  input  logic       exe_fire,
  input  logic       mem_fire,
  input  logic       wb_retire,
  output logic       id_ready_go,
  output logic [1:0] byp_sel_rs,
  output logic [1:0] byp_sel_rt
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  slot_t exe_r;
  slot_t mem_r;
  slot_t wb_r;
  logic  haz_rs_s;
  logic  haz_rt_s;
  logic  id_ready_go_s;

  // Slot pipeline: each slot samples its predecessor's pre-edge value, load beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exe_r <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      if (id_fire) begin
        exe_r <= '{valid: 1'b1, waddr: id_w_addr, wen: id_w_en,
                   avail: id_exe_gene, mem_gene: id_mem_gene};
      end else if (exe_fire) begin
        exe_r.valid <= 1'b0;
      end

      if (exe_fire) begin
        mem_r <= '{valid: exe_r.valid, waddr: exe_r.waddr, wen: exe_r.wen,
                   avail: exe_r.avail | exe_r.mem_gene, mem_gene: exe_r.mem_gene};
      end else if (mem_fire) begin
        mem_r.valid <= 1'b0;
      end

      if (mem_fire) begin
        wb_r <= '{valid: mem_r.valid, waddr: mem_r.waddr, wen: mem_r.wen,
                  avail: 1'b1, mem_gene: mem_r.mem_gene};
      end else if (wb_retire) begin
        wb_r.valid <= 1'b0;
      end
    end
  end

  haz_src_match u_match_rs (
    .src_addr (id_rs_addr),
    .src_en   (id_rs_en),
    .exe_slot (exe_r),
    .mem_slot (mem_r),
    .wb_slot  (wb_r),
    .hazard   (haz_rs_s),
    .byp_sel  (byp_sel_rs)
  );

  haz_src_match u_match_rt (
    .src_addr (id_rt_addr),
    .src_en   (id_rt_en),
    .exe_slot (exe_r),
    .mem_slot (mem_r),
    .wb_slot  (wb_r),
    .hazard   (haz_rt_s),
    .byp_sel  (byp_sel_rt)
  );

  // ready_go must be same-cycle with ID, so it is left combinational.
  assign id_ready_go_s = ~(haz_rs_s | haz_rt_s);
  assign id_ready_go   = id_ready_go_s;

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles a valid ID instruction is held by a hazard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (id_valid & ~id_ready_go_s & (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  logic unused_valid_s;
  assign unused_valid_s = id_valid;
`endif

endmodule

// File: tb/tb_id_hazard_sched.sv
// Self-checking bench for id_hazard_sched: directed scenarios then random
// traffic checked against a stage-indexed in-flight instruction model.
module tb_id_hazard_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic        id_rs_en;
  logic [4:0]  id_rt_addr;
  logic        id_rt_en;
  logic [4:0]  id_w_addr;
  logic        id_w_en;
  logic        id_exe_gene;
  logic        id_mem_gene;
  logic        id_fire;
  logic        exe_fire;
  logic        mem_fire;
  logic        wb_retire;
  logic        id_ready_go;
  logic [1:0]  byp_sel_rs;
  logic [1:0]  byp_sel_rt;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int fails   = 0;

  // In-flight instruction per stage (0=EXE,1=MEM,2=WB); ps = first stage whose
  // index makes the result forwardable.
  typedef struct {
    bit       v;
    bit [4:0] a;
    bit       w;
    int       ps;
  } ins_t;
  ins_t st[3];
  int unsigned exp_cnt;

  always #5 clk = ~clk;

  id_hazard_sched dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs_addr  (id_rs_addr),
    .id_rs_en    (id_rs_en),
    .id_rt_addr  (id_rt_addr),
    .id_rt_en    (id_rt_en),
    .id_w_addr   (id_w_addr),
    .id_w_en     (id_w_en),
    .id_exe_gene (id_exe_gene),
    .id_mem_gene (id_mem_gene),
    .id_fire     (id_fire),
    .exe_fire    (exe_fire),
    .mem_fire    (mem_fire),
    .wb_retire   (wb_retire),
    .id_ready_go (id_ready_go),
    .byp_sel_rs  (byp_sel_rs),
    .byp_sel_rt  (byp_sel_rt)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    vectors++;
    assert (obs === ex) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  function automatic void model_src(input bit [4:0] s, input bit en, output bit [1:0] sel, output bit haz);
    sel = 2'd0;
    haz = 1'b0;
    if (en && s != 5'd0) begin
      for (int k = 0; k < 3; k++) begin
        if (st[k].v && st[k].w && st[k].a == s) begin
          sel = 2'(k + 1);
          haz = (k < st[k].ps);
          break;
        end
      end
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) st[k] = '{v: 1'b0, a: 5'd0, w: 1'b0, ps: 0};
    exp_cnt = 0;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs, input logic rse,
                       input logic [4:0] rt, input logic rte, input logic [4:0] w,
                       input logic we, input logic eg, input logic mg, input logic idf,
                       input logic exf, input logic mf, input logic wr);
    id_valid = v;   id_rs_addr = rs; id_rs_en = rse; id_rt_addr = rt; id_rt_en = rte;
    id_w_addr = w;  id_w_en = we;    id_exe_gene = eg; id_mem_gene = mg;
    id_fire = idf;  exe_fire = exf;  mem_fire = mf;  wb_retire = wr;
  endtask

  // Check outputs against the model, clock once, advance the model.
  task automatic step(input string tag);
    bit [1:0] sel_rs, sel_rt;
    bit       hz_rs, hz_rt;
    ins_t     n0, n1, n2;
    #2;
    model_src(id_rs_addr, id_rs_en, sel_rs, hz_rs);
    model_src(id_rt_addr, id_rt_en, sel_rt, hz_rt);
    chk({tag, ".ready"}, {31'd0, id_ready_go}, {31'd0, ~(hz_rs | hz_rt)});
    chk({tag, ".sel_rs"}, {30'd0, byp_sel_rs}, {30'd0, sel_rs});
    chk({tag, ".sel_rt"}, {30'd0, byp_sel_rt}, {30'd0, sel_rt});
`ifdef HAZ_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, exp_cnt);
`endif
    @(posedge clk);
    if (id_valid && (hz_rs || hz_rt) && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    n0 = st[0]; n1 = st[1]; n2 = st[2];
    if (mem_fire) n2 = st[1]; else if (wb_retire) n2.v = 1'b0;
    if (exe_fire) n1 = st[0]; else if (mem_fire) n1.v = 1'b0;
    if (id_fire) n0 = '{v: 1'b1, a: id_w_addr, w: id_w_en,
                        ps: id_exe_gene ? 0 : (id_mem_gene ? 1 : 2)};
    else if (exe_fire) n0.v = 1'b0;
    st[0] = n0; st[1] = n1; st[2] = n2;
    @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      step("flush");
    end
  endtask

  initial begin
    model_clear();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12 reset = 1'b1;
    @(negedge clk);

    // Reset state with an enabled source.
    drive(0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst.ready", {31'd0, id_ready_go}, 32'd1);
    chk("rst.sel_rs", {30'd0, byp_sel_rs}, 32'd0);
    step("rst");

    // ALU writer r3 forwarded from EXE.
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 0, 0, 0);
    step("addu_fire");
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("addu.sel_rs", {30'd0, byp_sel_rs}, 32'd1);
    chk("addu.ready", {31'd0, id_ready_go}, 32'd1);
    step("addu_use");
    flush();

    // Load r4: one stall cycle, then forwarded from MEM.
    drive(0, 0, 0, 0, 0, 4, 1, 0, 1, 1, 0, 0, 0);
    step("lw_fire");
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("lw.stall", {31'd0, id_ready_go}, 32'd0);
    step("lw_stall");
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lw.ready", {31'd0, id_ready_go}, 32'd1);
    chk("lw.sel_rt", {30'd0, byp_sel_rt}, 32'd2);
`ifdef HAZ_STALL_CNT_EN
    chk("lw.stall_cnt", stall_cnt, 32'd1);
`endif
    step("lw_use");
    flush();

    // Two writers of r7: youngest (EXE) wins.
    drive(0, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0);
    step("r7_a");
    drive(0, 0, 0, 0, 0, 7, 1, 1, 0, 1, 1, 0, 0);
    step("r7_b");
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r7.sel_rs", {30'd0, byp_sel_rs}, 32'd1);
    step("r7_use");
    flush();

    // $0 is never hazarded or forwarded.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("r0_fire");
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0.ready", {31'd0, id_ready_go}, 32'd1);
    chk("r0.sel_rs", {30'd0, byp_sel_rs}, 32'd0);
    step("r0_use");
    flush();

    // Same-cycle fire chain: slots shift by one, nothing lost.
    drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    step("chain_a");
    drive(0, 0, 0, 0, 0, 2, 1, 1, 0, 1, 1, 0, 0);
    step("chain_b");
    drive(0, 0, 0, 0, 0, 3, 1, 1, 0, 1, 1, 1, 0);
    step("chain_c");
    drive(0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 1, 1);
    step("chain_d");
    drive(1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("chain.sel_rs_wb", {30'd0, byp_sel_rs}, 32'd3);
    chk("chain.sel_rt_mem", {30'd0, byp_sel_rt}, 32'd2);
    step("chain_use");

    // Asynchronous reset mid-stream clears selects without a clock edge.
    drive(1, 4, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("prerst.ready", {31'd0, id_ready_go}, 32'd0);
    reset = 1'b0;
    #1 chk("arst.ready", {31'd0, id_ready_go}, 32'd1);
    chk("arst.sel_rs", {30'd0, byp_sel_rs}, 32'd0);
    chk("arst.sel_rt", {30'd0, byp_sel_rt}, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
